// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential ICCM fetch into a PC-tagged prefetch queue feeding dec.
// Latency: request -> instr_valid_o in 2 cycles, or 1 cycle with IFU_PREFETCH_BYPASS_EN into an empty queue.
// Backpressure: stall_i holds the head; issue stops once queued + inflight reaches DEPTH; flush_i overrides all.
//
// Optional feature macro: IFU_PREFETCH_BYPASS_EN (response forwarded straight to decode when queue empty).
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   iccm_rd_en/iccm_rd_addr     read request and word address (PC)
//   iccm_rd_data                read data, one cycle after the request
//   flush_i/flush_addr_i        redirect from exe and its target
//   stall_i                     decoder cannot accept the head this cycle
//   instr_valid_o/instr_o/instr_addr_o  queue head (zeroed when not valid)
//   fifo_count_o                registered queue occupancy (excludes inflight)

// Generic clearable FIFO; storage is not reset, only pointers and count.
module ifu_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop_vld,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !(rst || clr)) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        iccm_rd_en,
  output logic [31:0]                 iccm_rd_addr,
  input  logic [31:0]                 iccm_rd_data,
  input  logic                        flush_i,
  input  logic [31:0]                 flush_addr_i,
  input  logic                        stall_i,
  output logic                        instr_valid_o,
  output logic [31:0]                 instr_o,
  output logic [31:0]                 instr_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count_o
);
  localparam int          CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] pc;
  logic [31:0] req_addr;     // address of the request whose data arrives this cycle
  logic        inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  entry_t      push_dat;
  entry_t      head_dat;
  logic        push_vld;
  logic        pop_vld;
  logic        head_vld;
  logic        byp_vld;
  logic        flush_addr_unused;

  assign flush_addr_unused = ^flush_addr_i[1:0];

  // Issue ignores a same-cycle pop, so a response always has a free slot.
  assign occupancy    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign iccm_rd_en   = !rst && !flush_i && (occupancy < DEPTH_W);
  assign iccm_rd_addr = pc;

`ifdef IFU_PREFETCH_BYPASS_EN
  // Empty queue and decode ready: hand the response straight to decode.
  assign byp_vld = (count == '0) && inflight && !flush_i && !rst && !stall_i;
`else
  assign byp_vld = 1'b0;
`endif

  assign head_vld = (count != '0);
  assign push_vld = inflight && !flush_i && !rst && !byp_vld;
  assign pop_vld  = head_vld && !stall_i && !flush_i && !rst;
  assign push_dat = '{addr: req_addr, instr: iccm_rd_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= '0;
      inflight <= 1'b0;
    end else if (flush_i) begin
      // Any response arriving this cycle is dropped with inflight.
      pc       <= {flush_addr_i[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= iccm_rd_en;
      if (iccm_rd_en) begin
        req_addr <= pc;
        pc       <= pc + 32'd4;
      end
    end
  end

  ifu_prefetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_i),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (count)
  );

  // The head still shows during a flush cycle; dec squashes it on its own.
  always_comb begin
    instr_valid_o = head_vld || byp_vld;
    instr_o       = '0;
    instr_addr_o  = '0;
    if (head_vld) begin
      instr_o      = head_dat.instr;
      instr_addr_o = head_dat.addr;
    end else if (byp_vld) begin
      instr_o      = iccm_rd_data;
      instr_addr_o = req_addr;
    end
  end

  assign fifo_count_o = count;
endmodule
